// File: rtl/apb_spi_ctrl_pkg.sv
// Shared definitions for the APB-to-SPI bridge: word size, handshake levels,
// register offsets, STATUS/CTRL bit positions and the transfer FSM states.
package apb_spi_ctrl_pkg;

   localparam int WORD_LENGTH = 8;
   localparam logic SPI_READY = 1'b1;
   localparam logic APB_READY = 1'b1;

   localparam logic [3:0] ADDR_TXDATA = 4'h0;
   localparam logic [3:0] ADDR_RXDATA = 4'h4;
   localparam logic [3:0] ADDR_STATUS = 4'h8;
   localparam logic [3:0] ADDR_CTRL   = 4'hC;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_RX_VALID = 1;
   localparam int ST_BUSY     = 2;
   localparam int ST_RX_OVR   = 3;
   localparam int CTRL_IRQ_EN = 0;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_DRAIN     = 2'd3
   } spi_state_t;

endpackage

// File: rtl/apb_spi_regs.sv
// APB register decode: purely combinational, the access completes in the PSEL&PENABLE cycle.
// Never stalls (no wait states); illegal accesses raise PSLVERR and produce no update strobes.
module apb_spi_regs
   import apb_spi_ctrl_pkg::*;
(
   input  logic                   PSEL,
   input  logic                   PENABLE,
   input  logic                   PWRITE,
   input  logic [3:0]             PADDR,
   input  logic [31:0]            PWDATA,
   output logic [31:0]            PRDATA,
   output logic                   PSLVERR,
   input  logic                   tx_full,
   input  logic                   rx_valid,
   input  logic                   rx_ovr,
   input  logic                   busy,
   input  logic                   in_start,
   input  logic                   irq_en,
   input  logic [WORD_LENGTH-1:0] rx_reg,
   output logic                   tx_wr,
   output logic [WORD_LENGTH-1:0] tx_dat,
   output logic                   rx_rd,
   output logic                   ovr_clr,
   output logic                   ctrl_wr,
   output logic                   ctrl_dat
);

   logic access;
   logic unused_pwdata;

   assign access        = PSEL & PENABLE;
   assign tx_dat        = PWDATA[WORD_LENGTH-1:0];
   assign ctrl_dat      = PWDATA[CTRL_IRQ_EN];
   assign unused_pwdata = ^PWDATA[31:WORD_LENGTH];

   always_comb begin
      PRDATA  = '0;
      PSLVERR = 1'b0;
      tx_wr   = 1'b0;
      rx_rd   = 1'b0;
      ovr_clr = 1'b0;
      ctrl_wr = 1'b0;
      if (access && PWRITE) begin
         case (PADDR)
            // a new byte may replace tx_hold only in the cycle it is being launched
            ADDR_TXDATA: if (tx_full && !in_start) PSLVERR = 1'b1;
                         else                      tx_wr   = 1'b1;
            ADDR_RXDATA: PSLVERR = 1'b1;
            ADDR_STATUS: ovr_clr = PWDATA[ST_RX_OVR];
            ADDR_CTRL:   ctrl_wr = 1'b1;
            default:     ;
         endcase
      end else if (access) begin
         case (PADDR)
            ADDR_TXDATA: PSLVERR = 1'b1;
            ADDR_RXDATA: begin
               PRDATA = 32'(rx_reg);
               rx_rd  = 1'b1;
            end
            ADDR_STATUS: begin
               PRDATA[ST_TX_FULL]  = tx_full;
               PRDATA[ST_RX_VALID] = rx_valid;
               PRDATA[ST_BUSY]     = busy;
               PRDATA[ST_RX_OVR]   = rx_ovr;
            end
            ADDR_CTRL:   PRDATA[CTRL_IRQ_EN] = irq_en;
            default:     ;
         endcase
      end
   end

endmodule

// File: rtl/apb_spi_ctrl.sv
// APB slave driving one SPI master byte transfer at a time; TXDATA write to spi_start is 2 cycles
// when the master is ready. A second byte is held in tx_hold; further writes get PSLVERR.
module apb_spi_ctrl
   import apb_spi_ctrl_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   PSEL,
   input  logic                   PENABLE,
   input  logic                   PWRITE,
   input  logic [3:0]             PADDR,
   input  logic [31:0]            PWDATA,
   output logic [31:0]            PRDATA,
   output logic                   PREADY,
   output logic                   PSLVERR,
   output logic                   irq,
   output logic                   spi_start,
   output logic [WORD_LENGTH-1:0] spi_wdata,
   input  logic [WORD_LENGTH-1:0] spi_rdata,
   input  logic                   spi_rx_valid,
   input  logic                   spi_rdy_bsybar
);

   spi_state_t state, next_state;

   logic                   tx_full, rx_valid, rx_ovr, irq_en, busy;
   logic                   launch, capture;
   logic [WORD_LENGTH-1:0] tx_hold, rx_reg;
   logic                   tx_wr, rx_rd, ovr_clr, ctrl_wr, ctrl_dat;
   logic [WORD_LENGTH-1:0] tx_dat;

   apb_spi_regs u_regs (
      .PSEL     (PSEL),
      .PENABLE  (PENABLE),
      .PWRITE   (PWRITE),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PRDATA   (PRDATA),
      .PSLVERR  (PSLVERR),
      .tx_full  (tx_full),
      .rx_valid (rx_valid),
      .rx_ovr   (rx_ovr),
      .busy     (busy),
      .in_start (spi_start),
      .irq_en   (irq_en),
      .rx_reg   (rx_reg),
      .tx_wr    (tx_wr),
      .tx_dat   (tx_dat),
      .rx_rd    (rx_rd),
      .ovr_clr  (ovr_clr),
      .ctrl_wr  (ctrl_wr),
      .ctrl_dat (ctrl_dat)
   );

   assign PREADY = APB_READY;
   assign irq    = rx_valid & irq_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:      if (tx_full && (spi_rdy_bsybar == SPI_READY)) next_state = S_START;
         S_START:     next_state = S_WAIT_DONE;
         S_WAIT_DONE: if (spi_rx_valid)  next_state = S_DRAIN;
         S_DRAIN:     if (!spi_rx_valid) next_state = S_IDLE;
         default:     next_state = S_IDLE;
      endcase
   end

   always_comb begin
      spi_start = (state == S_START);
      busy      = (state != S_IDLE);
      launch    = (state == S_IDLE) && (next_state == S_START);
      capture   = (state == S_WAIT_DONE) && spi_rx_valid;
   end

   // spi_wdata loads on entry to START so the byte is stable while spi_start is high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_hold   <= '0;
         tx_full   <= 1'b0;
         spi_wdata <= '0;
         rx_reg    <= '0;
         rx_valid  <= 1'b0;
         rx_ovr    <= 1'b0;
         irq_en    <= 1'b0;
      end else begin
         if (tx_wr) tx_hold <= tx_dat;

         if (tx_wr)          tx_full <= 1'b1;
         else if (spi_start) tx_full <= 1'b0;

         if (launch) spi_wdata <= tx_hold;

         if (capture) rx_reg <= spi_rdata;

         if (capture)    rx_valid <= 1'b1;
         else if (rx_rd) rx_valid <= 1'b0;

         // a read racing the capture consumes the old byte, so it is not an overrun
         if (capture && rx_valid && !rx_rd) rx_ovr <= 1'b1;
         else if (ovr_clr)                  rx_ovr <= 1'b0;

         if (ctrl_wr) irq_en <= ctrl_dat;
      end
   end

endmodule

// File: tb/tb_apb_spi_ctrl.sv
// Scoreboard bench for apb_spi_ctrl: stimulus pushes expected APB responses and SPI launches,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_apb_spi_ctrl;
   import apb_spi_ctrl_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   PSEL, PENABLE, PWRITE;
   logic [3:0]             PADDR;
   logic [31:0]            PWDATA, PRDATA;
   logic                   PREADY, PSLVERR, irq, spi_start;
   logic [WORD_LENGTH-1:0] spi_wdata, spi_rdata;
   logic                   spi_rx_valid, spi_rdy_bsybar;

   apb_spi_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .PSEL           (PSEL),
      .PENABLE        (PENABLE),
      .PWRITE         (PWRITE),
      .PADDR          (PADDR),
      .PWDATA         (PWDATA),
      .PRDATA         (PRDATA),
      .PREADY         (PREADY),
      .PSLVERR        (PSLVERR),
      .irq            (irq),
      .spi_start      (spi_start),
      .spi_wdata      (spi_wdata),
      .spi_rdata      (spi_rdata),
      .spi_rx_valid   (spi_rx_valid),
      .spi_rdy_bsybar (spi_rdy_bsybar)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  addr;
      logic [31:0] dat;
      logic        err;
   } apb_exp_t;

   typedef struct packed {
      logic [7:0]         wdat;
      logic signed [31:0] cyc;
   } start_exp_t;

   apb_exp_t   apb_q[$];
   start_exp_t start_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;

   // transaction-level model of the register file
   logic       m_tx_full, m_busy, m_rx_valid, m_rx_ovr, m_irq_en, m_ready;
   logic [7:0] m_tx_hold, m_rx_reg;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_tx_full = 0; m_busy = 0; m_rx_valid = 0; m_rx_ovr = 0; m_irq_en = 0;
      m_tx_hold = 0; m_rx_reg = 0;
   endtask

   function automatic logic [31:0] status_exp();
      return {28'd0, m_rx_ovr, m_busy, m_rx_valid, m_tx_full};
   endfunction

   task automatic launch(input logic [7:0] b, input int c);
      start_exp_t e;
      e.wdat = b;
      e.cyc  = c;
      start_q.push_back(e);
      m_busy = 1;
   endtask

   // called and returns at posedge+1; consecutive calls give back-to-back APB transfers
   task automatic apb_access(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_dat, input logic exp_err,
                             input logic cap, input logic [7:0] cap_dat, output int acc);
      apb_exp_t e;
      e.addr = a; e.dat = exp_dat; e.err = exp_err;
      apb_q.push_back(e);
      PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = wd;
      @(posedge clk); #1;
      PENABLE = 1; acc = cyc;
      if (cap) begin spi_rx_valid = 1; spi_rdata = cap_dat; end
      @(posedge clk); #1;
      PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = 0; spi_rx_valid = 0;
   endtask

   task automatic apb_tx(input logic [7:0] b);
      int   acc;
      logic err;
      err = m_tx_full;
      apb_access(1, ADDR_TXDATA, {24'($urandom), b}, 0, err, 0, 0, acc);
      if (!err) begin
         if (!m_busy && m_ready) launch(b, acc + 2);
         else begin m_tx_full = 1; m_tx_hold = b; end
      end
   endtask

   task automatic apb_wr(input logic [3:0] a, input logic [31:0] d);
      int acc;
      if (a == ADDR_TXDATA) apb_tx(d[7:0]);
      else begin
         apb_access(1, a, d, 0, (a == ADDR_RXDATA), 0, 0, acc);
         if (a == ADDR_STATUS && d[3]) m_rx_ovr = 0;
         if (a == ADDR_CTRL) m_irq_en = d[0];
      end
   endtask

   task automatic apb_rd(input logic [3:0] a);
      int          acc;
      logic [31:0] ed;
      ed = (a == ADDR_RXDATA) ? 32'(m_rx_reg) : (a == ADDR_STATUS) ? status_exp() :
           (a == ADDR_CTRL)   ? 32'(m_irq_en) : 32'd0;
      apb_access(0, a, 0, ed, (a == ADDR_TXDATA), 0, 0, acc);
      if (a == ADDR_RXDATA) m_rx_valid = 0;
   endtask

   task automatic complete(input logic [7:0] r);
      spi_rdata = r; spi_rx_valid = 1;
      @(posedge clk); #1;
      spi_rx_valid = 0;
      if (m_rx_valid) m_rx_ovr = 1;
      m_rx_reg = r; m_rx_valid = 1; m_busy = 0;
      if (m_tx_full && m_ready) begin m_tx_full = 0; launch(m_tx_hold, -1); end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic wait_start();
      int n = 0;
      while (start_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
      n_cmp++;
      if (start_q.size() != 0) begin
         n_bad++;
         $display("FAIL start_timeout pending=%0d required=0", start_q.size());
         start_q.delete();
      end
   endtask

   task automatic check_irq();
      check("irq", 32'(irq), 32'(m_irq_en & m_rx_valid));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_spi_start"}, 32'(spi_start), 0);
      check({tag, "_spi_wdata"}, 32'(spi_wdata), 0);
      check({tag, "_irq"},       32'(irq), 0);
      check({tag, "_prdata"},    PRDATA, 0);
      check({tag, "_pslverr"},   32'(PSLVERR), 0);
      check({tag, "_pready"},    32'(PREADY), 1);
   endtask

   // monitor: every APB access and every spi_start cycle consumes one expectation
   initial begin
      apb_exp_t   ae;
      start_exp_t se;
      forever begin
         @(negedge clk);
         if (!rst) begin
            n_cmp++;
            if (PSEL && PENABLE) begin
               if (apb_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL apb_unexpected addr=%h", PADDR);
               end else begin
                  ae = apb_q.pop_front();
                  if (PRDATA !== ae.dat || PSLVERR !== ae.err || PREADY !== 1'b1) begin
                     n_bad++;
                     $display("FAIL apb addr=%h actual PRDATA=%h PSLVERR=%b PREADY=%b required PRDATA=%h PSLVERR=%b PREADY=1",
                              ae.addr, PRDATA, PSLVERR, PREADY, ae.dat, ae.err);
                  end
               end
            end else if (PRDATA !== 32'd0 || PSLVERR !== 1'b0) begin
               n_bad++;
               $display("FAIL apb_idle actual PRDATA=%h PSLVERR=%b required 0/0", PRDATA, PSLVERR);
            end
            if (spi_start) begin
               n_cmp++;
               if (start_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL start_unexpected cycle=%0d wdata=%h", cyc, spi_wdata);
               end else begin
                  se = start_q.pop_front();
                  if (spi_wdata !== se.wdat || (se.cyc >= 0 && cyc != se.cyc)) begin
                     n_bad++;
                     $display("FAIL start actual wdata=%h cycle=%0d required wdata=%h cycle=%0d",
                              spi_wdata, cyc, se.wdat, se.cyc);
                  end
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [7:0]  b, r;
      logic [31:0] d;
      rst = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
      spi_rdata = 0; spi_rx_valid = 0; spi_rdy_bsybar = SPI_READY;
      m_ready = 1;
      model_reset();
      @(negedge clk);
      check_reset_outputs("por");
      @(posedge clk); #1;
      rst = 0;
      apb_rd(ADDR_STATUS);
      apb_rd(ADDR_CTRL);
      apb_rd(ADDR_RXDATA);
      apb_rd(ADDR_TXDATA);

      // single transfer with interrupt
      apb_wr(ADDR_CTRL, 32'h1);
      apb_rd(ADDR_CTRL);
      apb_tx(8'hA5);
      repeat (3) @(posedge clk);
      #1;
      apb_rd(ADDR_STATUS);
      check_irq();
      complete(8'h3C);
      apb_rd(ADDR_STATUS);
      check_irq();
      apb_rd(ADDR_RXDATA);
      apb_rd(ADDR_STATUS);
      check_irq();

      // held byte, rejected third write, then overrun
      apb_tx(8'h5A);
      wait_start();
      apb_tx(8'h11);
      apb_tx(8'h22);
      apb_rd(ADDR_STATUS);
      complete(8'h77);
      wait_start();
      complete(8'h99);
      apb_rd(ADDR_STATUS);
      apb_rd(ADDR_RXDATA);
      apb_wr(ADDR_STATUS, 32'h8);
      apb_rd(ADDR_STATUS);

      // write landing in the START cycle is accepted and queued
      apb_tx(8'h71);
      apb_tx(8'h72);
      apb_rd(ADDR_STATUS);
      wait_start();
      complete(8'h01);
      wait_start();
      complete(8'h02);
      apb_rd(ADDR_RXDATA);
      apb_wr(ADDR_STATUS, 32'h8);

      // RXDATA read coinciding with a capture
      apb_tx(8'h42);
      wait_start();
      complete(8'h10);
      apb_tx(8'h43);
      wait_start();
      begin
         int acc;
         apb_access(0, ADDR_RXDATA, 0, 32'(m_rx_reg), 0, 1, 8'h20, acc);
         m_rx_reg = 8'h20; m_rx_valid = 1; m_busy = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      apb_rd(ADDR_STATUS);
      apb_rd(ADDR_RXDATA);

      // reset in the middle of a transfer
      apb_tx(8'h55);
      wait_start();
      rst = 1;
      @(negedge clk);
      check_reset_outputs("midrst");
      @(posedge clk); #1;
      rst = 0;
      model_reset();
      apb_rd(ADDR_STATUS);
      apb_rd(ADDR_CTRL);
      apb_tx(8'h66);
      wait_start();
      complete(8'h67);
      apb_rd(ADDR_RXDATA);

      // randomized traffic
      for (int i = 0; i < 24; i++) begin
         b = 8'($urandom);
         r = 8'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            spi_rdy_bsybar = ~SPI_READY; m_ready = 0;
            apb_tx(b);
            @(posedge clk); #1;
            apb_rd(ADDR_STATUS);
            apb_tx(~b);
            spi_rdy_bsybar = SPI_READY; m_ready = 1;
            m_tx_full = 0; launch(m_tx_hold, -1);
         end else begin
            apb_tx(b);
         end
         wait_start();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         complete(r);
         d = $urandom;
         case ($urandom_range(0, 4))
            0: apb_rd(ADDR_RXDATA);
            1: apb_rd(ADDR_STATUS);
            2: apb_wr(ADDR_STATUS, d);
            3: apb_wr(ADDR_CTRL, d);
            default: apb_wr(ADDR_RXDATA, d);
         endcase
         check_irq();
         apb_rd(ADDR_STATUS);
      end

      repeat (4) @(posedge clk);
      #1;
      check("apb_q_drained", 32'(apb_q.size()), 0);
      check("start_q_drained", 32'(start_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
